wrlvl_sequencer: RTL and testbench



---
 rtl/wrlvl_seq_pkg.sv | 39 +++
 rtl/wrlvl_seq_timer.sv | 27 ++
 rtl/wrlvl_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_wrlvl_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wrlvl_seq_pkg.sv
// Shared definitions for the write-leveling sequencer: state encoding,
// counter width and parameter legality check.
package wrlvl_seq_pkg;

   localparam int unsigned CNT_W = 8;

   // One-hot state codes
   localparam logic [5:0] S_IDLE  = 6'b000001;
   localparam logic [5:0] S_SETUP = 6'b000010;
   localparam logic [5:0] S_STRB  = 6'b000100;
   localparam logic [5:0] S_GAP   = 6'b001000;
   localparam logic [5:0] S_CLOSE = 6'b010000;
   localparam logic [5:0] S_EXIT  = 6'b100000;

   typedef enum logic [5:0] {
      ST_IDLE  = S_IDLE,
      ST_SETUP = S_SETUP,
      ST_STRB  = S_STRB,
      ST_GAP   = S_GAP,
      ST_CLOSE = S_CLOSE,
      ST_EXIT  = S_EXIT
   } state_t;

   // True when every parameter lies in its legal range
   function automatic bit params_ok(input int unsigned num_lanes,
                                    input int unsigned num_ranks,
                                    input int unsigned wlmrd_cyc,
                                    input int unsigned strobe_gap,
                                    input int unsigned max_strobes,
                                    input int unsigned exit_cyc);
      return (num_lanes >= 1) &&
             (num_ranks == 1 || num_ranks == 2) &&
             (wlmrd_cyc >= 1 && wlmrd_cyc <= 255) &&
             (strobe_gap >= 2 && strobe_gap <= 255) &&
             (max_strobes >= 1 && max_strobes <= 255) &&
             (exit_cyc >= 2 && exit_cyc <= 255);
   endfunction

endpackage

// File: rtl/wrlvl_seq_timer.sv
// Loadable down-counter with a zero flag; times SETUP, GAP and EXIT.
module wrlvl_seq_timer
   import wrlvl_seq_pkg::*;
(
   input  logic             sclk,
   input  logic             reset_b,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero_c
);

   logic [CNT_W-1:0] cnt;

   // Load has priority; otherwise count down and park at zero
   always_ff @(posedge sclk or negedge reset_b) begin
      if (!reset_b) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero_c = (cnt == '0);

endmodule

// File: rtl/wrlvl_sequencer.sv
// Per-rank write-leveling sequencer: opens the window, issues periodic
// strobes until all lanes respond or the budget runs out, records failures.
module wrlvl_sequencer
   import wrlvl_seq_pkg::*;
#(
   parameter int unsigned NUM_LANES   = 2,
   parameter int unsigned NUM_RANKS   = 1,
   parameter int unsigned WLMRD_CYC   = 40,
   parameter int unsigned STROBE_GAP  = 32,
   parameter int unsigned MAX_STROBES = 160,
   parameter int unsigned EXIT_CYC    = 4
)(
   input  logic                 sclk,
   input  logic                 reset_b,
   input  logic                 start,
   input  logic [NUM_LANES-1:0] dfi_wrlvl_resp,
   input  logic [NUM_LANES-1:0] lane_error,
   output logic                 dfi_wrlvl_en,
   output logic                 dfi_wrlvl_strobe,
   output logic                 dfi_wrlvl_cs_n,
   output logic                 busy,
   output logic                 done,
   output logic                 fail,
   output logic [NUM_LANES-1:0] fail_lanes
);

   if (!params_ok(NUM_LANES, NUM_RANKS, WLMRD_CYC, STROBE_GAP, MAX_STROBES, EXIT_CYC)) begin : g_param_err
      $error("wrlvl_sequencer: parameter out of range");
   end

   // Timer reload values: each state lasts (load value + 1) cycles
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(WLMRD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(STROBE_GAP - 2);
   localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_CYC - 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_STROBES);

   state_t               state;
   logic                 rank;
   logic [CNT_W-1:0]     strobe_cnt;
   logic [NUM_LANES-1:0] resp_seen;
   logic [NUM_LANES-1:0] err_seen;
   logic [NUM_LANES-1:0] close_fail_c;
   logic                 tmr_load_c;
   logic [CNT_W-1:0]     tmr_val_c;
   logic                 tmr_zero_c;
   logic                 resp_all_c;
   logic                 last_rank_c;
   logic                 sample_c;

   // A response arriving on the final GAP cycle still counts
   assign resp_all_c   = &(resp_seen | dfi_wrlvl_resp);
   assign last_rank_c  = (rank == 1'(NUM_RANKS - 1));
   assign sample_c     = dfi_wrlvl_en && (state != ST_SETUP);
   assign close_fail_c = fail_lanes | ~resp_seen | err_seen;

   // Timer reload at the edge that enters a timed state
   always_comb begin
      tmr_load_c = 1'b0;
      tmr_val_c  = '0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               tmr_load_c = 1'b1;
               tmr_val_c  = SETUP_LD;
            end
         end
         ST_STRB: begin
            tmr_load_c = 1'b1;
            tmr_val_c  = GAP_LD;
         end
         ST_CLOSE: begin
            tmr_load_c = 1'b1;
            tmr_val_c  = EXIT_LD;
         end
         ST_EXIT: begin
            if (tmr_zero_c && !last_rank_c) begin
               tmr_load_c = 1'b1;
               tmr_val_c  = SETUP_LD;
            end
         end
         default: begin
            tmr_load_c = 1'b0;
         end
      endcase
   end

   wrlvl_seq_timer u_timer (
      .sclk     (sclk),
      .reset_b  (reset_b),
      .load     (tmr_load_c),
      .load_val (tmr_val_c),
      .zero_c   (tmr_zero_c)
   );

   // Sticky per-lane response and error capture within one window
   always_ff @(posedge sclk or negedge reset_b) begin
      if (!reset_b) begin
         resp_seen <= '0;
         err_seen  <= '0;
      end else if (state == ST_SETUP) begin
         resp_seen <= '0;
         err_seen  <= '0;
      end else if (sample_c) begin
         resp_seen <= resp_seen | dfi_wrlvl_resp;
         err_seen  <= err_seen | lane_error;
      end
   end

   // Sequencer state machine with registered outputs
   always_ff @(posedge sclk or negedge reset_b) begin
      if (!reset_b) begin
         state            <= ST_IDLE;
         rank             <= 1'b0;
         strobe_cnt       <= '0;
         dfi_wrlvl_en     <= 1'b0;
         dfi_wrlvl_strobe <= 1'b0;
         dfi_wrlvl_cs_n   <= 1'b1;
         busy             <= 1'b0;
         done             <= 1'b0;
         fail             <= 1'b0;
         fail_lanes       <= '0;
      end else begin
         dfi_wrlvl_strobe <= 1'b0;
         done             <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  fail_lanes   <= '0;
                  fail         <= 1'b0;
                  rank         <= 1'b0;
                  dfi_wrlvl_en <= 1'b1;
                  busy         <= 1'b1;
                  state        <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               strobe_cnt <= '0;
               if (tmr_zero_c) begin
                  dfi_wrlvl_strobe <= 1'b1;
                  state            <= ST_STRB;
               end
            end
            ST_STRB: begin
               if (strobe_cnt != MAX_CNT) begin
                  strobe_cnt <= strobe_cnt + CNT_W'(1);
               end
               state <= ST_GAP;
            end
            ST_GAP: begin
               if (tmr_zero_c) begin
                  if (resp_all_c || strobe_cnt == MAX_CNT) begin
                     dfi_wrlvl_en <= 1'b0;
                     state        <= ST_CLOSE;
                  end else begin
                     dfi_wrlvl_strobe <= 1'b1;
                     state            <= ST_STRB;
                  end
               end
            end
            ST_CLOSE: begin
               fail_lanes <= close_fail_c;
               fail       <= |close_fail_c;
               // Select the next rank while the window is shut
               dfi_wrlvl_cs_n <= last_rank_c;
               state          <= ST_EXIT;
            end
            ST_EXIT: begin
               if (tmr_zero_c) begin
                  if (!last_rank_c) begin
                     rank         <= rank + 1'b1;
                     dfi_wrlvl_en <= 1'b1;
                     state        <= ST_SETUP;
                  end else begin
                     rank  <= 1'b0;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wrlvl_sequencer.sv
// Directed bench for wrlvl_sequencer: single-rank and dual-rank instances.
module tb_wrlvl_sequencer;

   localparam int unsigned LANES = 2;
   localparam int unsigned WLMRD = 40;
   localparam int unsigned GAP   = 32;
   localparam int unsigned MAXS  = 10;
   localparam int unsigned EXITC = 4;

   logic             sclk;
   logic             reset_b;
   logic             start1;
   logic             start2;
   logic [LANES-1:0] resp;
   logic [LANES-1:0] lerr;

   logic             en1, strb1, cs1, busy1, done1, fail1;
   logic [LANES-1:0] fl1;
   logic             en2, strb2, cs2, busy2, done2, fail2;
   logic [LANES-1:0] fl2;

   // Observation mux: sel=0 watches the 1-rank instance, sel=1 the 2-rank one
   logic             sel;
   logic             o_en, o_strobe, o_cs_n, o_busy, o_done, o_fail;
   logic [LANES-1:0] o_fl;

   assign o_en     = sel ? en2   : en1;
   assign o_strobe = sel ? strb2 : strb1;
   assign o_cs_n   = sel ? cs2   : cs1;
   assign o_busy   = sel ? busy2 : busy1;
   assign o_done   = sel ? done2 : done1;
   assign o_fail   = sel ? fail2 : fail1;
   assign o_fl     = sel ? fl2   : fl1;

   int n_cmp = 0;
   int n_bad = 0;

   // Results of the last run_seq call
   int               m_en_rise, m_first_strb, m_strb, m_en_fall, m_done, m_done_cnt;
   int               m_windows, m_min_low;
   logic             m_cs_win0, m_cs_win1, m_cs_bad, m_cs_done;
   logic             m_busy_start, m_busy_done, m_fail, m_timeout;
   logic [LANES-1:0] m_fl, m_fl_start;

   wrlvl_sequencer #(
      .NUM_LANES(LANES), .NUM_RANKS(1), .WLMRD_CYC(WLMRD),
      .STROBE_GAP(GAP), .MAX_STROBES(MAXS), .EXIT_CYC(EXITC)
   ) dut1 (
      .sclk(sclk), .reset_b(reset_b), .start(start1),
      .dfi_wrlvl_resp(resp), .lane_error(lerr),
      .dfi_wrlvl_en(en1), .dfi_wrlvl_strobe(strb1), .dfi_wrlvl_cs_n(cs1),
      .busy(busy1), .done(done1), .fail(fail1), .fail_lanes(fl1)
   );

   wrlvl_sequencer #(
      .NUM_LANES(LANES), .NUM_RANKS(2), .WLMRD_CYC(WLMRD),
      .STROBE_GAP(GAP), .MAX_STROBES(MAXS), .EXIT_CYC(EXITC)
   ) dut2 (
      .sclk(sclk), .reset_b(reset_b), .start(start2),
      .dfi_wrlvl_resp(resp), .lane_error(lerr),
      .dfi_wrlvl_en(en2), .dfi_wrlvl_strobe(strb2), .dfi_wrlvl_cs_n(cs2),
      .busy(busy2), .done(done2), .fail(fail2), .fail_lanes(fl2)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   // Start one sequence and observe it at negedges. Lane i pulses its response
   // for one cycle, d_i cycles after the n_i-th strobe of each window (n_i=0: never).
   task automatic run_seq(input bit use2, input int n0, input int d0,
                          input int n1, input int d1, input bit err0, input int budget);
      int   c, wstrb, last_strb_c, low_run;
      logic prev_en, cs_prev;
      sel  = use2;
      resp = '0;
      lerr = '0;
      @(negedge sclk);
      if (use2) start2 = 1'b1; else start1 = 1'b1;
      @(negedge sclk);
      start1 = 1'b0;
      start2 = 1'b0;
      c = 1; wstrb = 0; last_strb_c = -1000; low_run = 0;
      prev_en = 1'b0; cs_prev = 1'b1;
      m_en_rise = -1; m_first_strb = -1; m_strb = 0; m_en_fall = -1;
      m_done = -1; m_done_cnt = 0; m_windows = 0; m_min_low = 1000;
      m_cs_win0 = 1'bx; m_cs_win1 = 1'bx; m_cs_bad = 1'b0; m_cs_done = 1'bx;
      m_busy_start = 1'bx; m_busy_done = 1'bx; m_fail = 1'bx; m_fl = 'x;
      m_fl_start = 'x; m_timeout = 1'b1;
      while (c < budget) begin
         if (o_en && !prev_en) begin
            m_windows++;
            wstrb = 0;
            if (m_windows == 1) begin
               m_en_rise = c; m_cs_win0 = o_cs_n; m_fl_start = o_fl; m_busy_start = o_busy;
            end else begin
               m_cs_win1 = o_cs_n;
               if (low_run < m_min_low) m_min_low = low_run;
            end
         end
         if (!o_en && prev_en && m_en_fall < 0) m_en_fall = c;
         if (o_en && prev_en && o_cs_n !== cs_prev) m_cs_bad = 1'b1;
         if (o_en) low_run = 0; else low_run++;
         if (o_strobe) begin
            m_strb++; wstrb++; last_strb_c = c;
            if (m_first_strb < 0) m_first_strb = c;
         end
         if (o_done) begin
            m_done_cnt++;
            if (m_done < 0) begin
               m_done = c; m_busy_done = o_busy; m_fail = o_fail; m_fl = o_fl; m_cs_done = o_cs_n;
            end
         end
         prev_en = o_en;
         cs_prev = o_cs_n;
         resp[0] = (n0 > 0) && (wstrb == n0) && (c == last_strb_c + d0);
         resp[1] = (n1 > 0) && (wstrb == n1) && (c == last_strb_c + d1);
         lerr[0] = err0 & resp[0];
         lerr[1] = 1'b0;
         if (m_done >= 0 && c >= m_done + 3) begin
            m_timeout = 1'b0;
            break;
         end
         @(negedge sclk);
         c++;
      end
      resp = '0;
      lerr = '0;
   endtask

   task automatic test_reset();
      sel = 1'b0;
      n_cmp++; if (en1 !== 1'b0)   begin n_bad++; $display("FAIL reset_en: got %b want 0", en1); end
      n_cmp++; if (strb1 !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b want 0", strb1); end
      n_cmp++; if (cs1 !== 1'b1)   begin n_bad++; $display("FAIL reset_cs_n: got %b want 1", cs1); end
      n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy1); end
      n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done1); end
      n_cmp++; if (fail1 !== 1'b0) begin n_bad++; $display("FAIL reset_fail: got %b want 0", fail1); end
      n_cmp++; if (fl1 !== 2'b00)  begin n_bad++; $display("FAIL reset_fail_lanes: got %b want 00", fl1); end
      n_cmp++; if (cs2 !== 1'b1)   begin n_bad++; $display("FAIL reset_cs_n_r2: got %b want 1", cs2); end
      n_cmp++; if (en2 !== 1'b0)   begin n_bad++; $display("FAIL reset_en_r2: got %b want 0", en2); end
   endtask

   task automatic test_basic();
      run_seq(1'b0, 5, 0, 5, 0, 1'b0, 1000);
      n_cmp++; if (m_timeout !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: no done within budget"); end
      n_cmp++; if (m_en_rise != 1) begin n_bad++; $display("FAIL basic_en_latency: got %0d want 1", m_en_rise); end
      n_cmp++; if (m_first_strb - m_en_rise != 40) begin n_bad++; $display("FAIL basic_wlmrd: got %0d want 40", m_first_strb - m_en_rise); end
      n_cmp++; if (m_strb != 5) begin n_bad++; $display("FAIL basic_strobes: got %0d want 5", m_strb); end
      n_cmp++; if (m_en_fall != m_first_strb + 5 * 32) begin n_bad++; $display("FAIL basic_en_fall: got %0d want %0d", m_en_fall, m_first_strb + 160); end
      n_cmp++; if (m_done - m_en_fall != 5) begin n_bad++; $display("FAIL basic_done_delay: got %0d want 5", m_done - m_en_fall); end
      n_cmp++; if (m_done_cnt != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", m_done_cnt); end
      n_cmp++; if (m_fail !== 1'b0) begin n_bad++; $display("FAIL basic_fail: got %b want 0", m_fail); end
      n_cmp++; if (m_fl !== 2'b00) begin n_bad++; $display("FAIL basic_fail_lanes: got %b want 00", m_fl); end
      n_cmp++; if (m_busy_start !== 1'b1) begin n_bad++; $display("FAIL basic_busy_run: got %b want 1", m_busy_start); end
      n_cmp++; if (m_busy_done !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done: got %b want 0", m_busy_done); end
   endtask

   task automatic test_timeout();
      run_seq(1'b0, 1, 0, 0, 0, 1'b0, 1000);
      n_cmp++; if (m_timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_run: no done within budget"); end
      n_cmp++; if (m_strb != 10) begin n_bad++; $display("FAIL timeout_strobes: got %0d want 10", m_strb); end
      n_cmp++; if (m_en_fall != m_first_strb + 10 * 32) begin n_bad++; $display("FAIL timeout_en_fall: got %0d want %0d", m_en_fall, m_first_strb + 320); end
      n_cmp++; if (m_fl !== 2'b10) begin n_bad++; $display("FAIL timeout_fail_lanes: got %b want 10", m_fl); end
      n_cmp++; if (m_fail !== 1'b1) begin n_bad++; $display("FAIL timeout_fail: got %b want 1", m_fail); end
      n_cmp++; if (m_done_cnt != 1) begin n_bad++; $display("FAIL timeout_done_count: got %0d want 1", m_done_cnt); end
      repeat (10) @(negedge sclk);
      n_cmp++; if (fl1 !== 2'b10) begin n_bad++; $display("FAIL timeout_hold_lanes: got %b want 10", fl1); end
      n_cmp++; if (fail1 !== 1'b1) begin n_bad++; $display("FAIL timeout_hold_fail: got %b want 1", fail1); end
   endtask

   task automatic test_late_resp();
      // Lane 1 answers on the very cycle the budget expires
      run_seq(1'b0, 1, 0, 10, 31, 1'b0, 1000);
      n_cmp++; if (m_fl_start !== 2'b00) begin n_bad++; $display("FAIL late_cleared_on_start: got %b want 00", m_fl_start); end
      n_cmp++; if (m_strb != 10) begin n_bad++; $display("FAIL late_budget_strobes: got %0d want 10", m_strb); end
      n_cmp++; if (m_fl !== 2'b00) begin n_bad++; $display("FAIL late_budget_lanes: got %b want 00", m_fl); end
      n_cmp++; if (m_fail !== 1'b0) begin n_bad++; $display("FAIL late_budget_fail: got %b want 0", m_fail); end
      // Lane 1 answers on the last cycle of the third GAP
      run_seq(1'b0, 1, 0, 3, 31, 1'b0, 1000);
      n_cmp++; if (m_strb != 3) begin n_bad++; $display("FAIL gap_end_strobes: got %0d want 3", m_strb); end
      n_cmp++; if (m_en_fall != m_first_strb + 3 * 32) begin n_bad++; $display("FAIL gap_end_en_fall: got %0d want %0d", m_en_fall, m_first_strb + 96); end
      n_cmp++; if (m_fl !== 2'b00) begin n_bad++; $display("FAIL gap_end_lanes: got %b want 00", m_fl); end
   endtask

   task automatic test_resp_err();
      run_seq(1'b0, 2, 0, 2, 0, 1'b1, 1000);
      n_cmp++; if (m_strb != 2) begin n_bad++; $display("FAIL err_strobes: got %0d want 2", m_strb); end
      n_cmp++; if (m_fl !== 2'b01) begin n_bad++; $display("FAIL err_fail_lanes: got %b want 01", m_fl); end
      n_cmp++; if (m_fail !== 1'b1) begin n_bad++; $display("FAIL err_fail: got %b want 1", m_fail); end
   endtask

   task automatic test_two_ranks();
      run_seq(1'b1, 1, 0, 1, 0, 1'b0, 1000);
      n_cmp++; if (m_timeout !== 1'b0) begin n_bad++; $display("FAIL rank2_run: no done within budget"); end
      n_cmp++; if (m_windows != 2) begin n_bad++; $display("FAIL rank2_windows: got %0d want 2", m_windows); end
      n_cmp++; if (m_cs_win0 !== 1'b1) begin n_bad++; $display("FAIL rank2_cs_rank0: got %b want 1", m_cs_win0); end
      n_cmp++; if (m_cs_win1 !== 1'b0) begin n_bad++; $display("FAIL rank2_cs_rank1: got %b want 0", m_cs_win1); end
      n_cmp++; if (m_cs_bad !== 1'b0) begin n_bad++; $display("FAIL rank2_cs_stable: got %b want 0", m_cs_bad); end
      n_cmp++; if (m_min_low < 4) begin n_bad++; $display("FAIL rank2_en_low: got %0d want >=4", m_min_low); end
      n_cmp++; if (m_strb != 2) begin n_bad++; $display("FAIL rank2_strobes: got %0d want 2", m_strb); end
      n_cmp++; if (m_done_cnt != 1) begin n_bad++; $display("FAIL rank2_done_count: got %0d want 1", m_done_cnt); end
      n_cmp++; if (m_fail !== 1'b0) begin n_bad++; $display("FAIL rank2_fail: got %b want 0", m_fail); end
      n_cmp++; if (m_cs_done !== 1'b1) begin n_bad++; $display("FAIL rank2_cs_after: got %b want 1", m_cs_done); end
      sel = 1'b0;
   endtask

   task automatic test_busy_and_reset();
      int c, n_strb, first_strb, last_strb, en_cnt, done_cnt;
      sel = 1'b0; resp = '0; lerr = '0;
      @(negedge sclk); start1 = 1'b1;
      @(negedge sclk); start1 = 1'b0;
      c = 1; n_strb = 0; first_strb = -1; last_strb = -1;
      while (c < 89) begin
         start1 = (c == 10 || c == 50);
         if (o_strobe) begin
            n_strb++; last_strb = c;
            if (first_strb < 0) first_strb = c;
         end
         @(negedge sclk);
         c++;
      end
      start1 = 1'b0;
      n_cmp++; if (first_strb != 41) begin n_bad++; $display("FAIL restart_first_strobe: got %0d want 41", first_strb); end
      n_cmp++; if (last_strb != 73) begin n_bad++; $display("FAIL restart_second_strobe: got %0d want 73", last_strb); end
      n_cmp++; if (en1 !== 1'b1) begin n_bad++; $display("FAIL restart_en_midgap: got %b want 1", en1); end
      reset_b = 1'b0;
      #1;
      n_cmp++; if (en1 !== 1'b0) begin n_bad++; $display("FAIL async_reset_en: got %b want 0", en1); end
      n_cmp++; if (strb1 !== 1'b0) begin n_bad++; $display("FAIL async_reset_strobe: got %b want 0", strb1); end
      n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL async_reset_busy: got %b want 0", busy1); end
      repeat (2) @(negedge sclk);
      reset_b = 1'b1;
      en_cnt = 0; done_cnt = 0;
      repeat (60) begin
         @(negedge sclk);
         if (en1) en_cnt++;
         if (done1) done_cnt++;
      end
      n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL post_reset_done: got %0d want 0", done_cnt); end
      n_cmp++; if (en_cnt != 0) begin n_bad++; $display("FAIL post_reset_en: got %0d want 0", en_cnt); end
      run_seq(1'b0, 1, 0, 1, 0, 1'b0, 1000);
      n_cmp++; if (m_timeout !== 1'b0) begin n_bad++; $display("FAIL fresh_run: no done within budget"); end
      n_cmp++; if (m_en_rise != 1) begin n_bad++; $display("FAIL fresh_en_latency: got %0d want 1", m_en_rise); end
      n_cmp++; if (m_strb != 1) begin n_bad++; $display("FAIL fresh_strobes: got %0d want 1", m_strb); end
      n_cmp++; if (m_done_cnt != 1) begin n_bad++; $display("FAIL fresh_done_count: got %0d want 1", m_done_cnt); end
      n_cmp++; if (m_fail !== 1'b0) begin n_bad++; $display("FAIL fresh_fail: got %b want 0", m_fail); end
   endtask

   initial begin
      reset_b = 1'b0;
      start1  = 1'b0;
      start2  = 1'b0;
      resp    = '0;
      lerr    = '0;
      sel     = 1'b0;
      repeat (3) @(negedge sclk);
      reset_b = 1'b1;
      @(negedge sclk);
      test_reset();
      test_basic();
      test_timeout();
      test_late_resp();
      test_resp_err();
      test_two_ranks();
      test_busy_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
